delay_scan_ctrl: RTL and testbench

- Initiator side of the tap-delay change/done handshake; drives a cascaded delay-line control block.
- Steps the delay through a programmed tap range and waits for each update to complete.
- After each update, counts the 1s on the delayed data over a fixed sample window and streams one result per tap.
- Sits between the register/AXI front end and the delay-line block; used for eye scanning and calibration.

---
 rtl/delay_scan_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_delay_scan_ctrl.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_scan_ctrl.sv
// Tap-delay scan initiator: steps a delay line through a tap range,
// waits for each update, counts ones on the delayed data per tap.
module delay_scan_ctrl #(
    parameter int TAP_W       = 9,
    parameter int CNT_W       = 16,
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [TAP_W-1:0] tap_first,
    input  logic [TAP_W-1:0] tap_last,
    input  logic [TAP_W-1:0] tap_step,
    input  logic [CNT_W-1:0] sample_len,
    output logic             busy,
    output logic             scan_done,
    output logic             timeout_err,
    output logic             dly_change,
    output logic [TAP_W-1:0] dly_value,
    input  logic             dly_done,
    input  logic [TAP_W-1:0] dly_readback,
    input  logic             data_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [TAP_W-1:0] res_tap,
    output logic [TAP_W-1:0] res_readback,
    output logic [CNT_W-1:0] res_ones
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SETTLE,
        S_SAMPLE,
        S_REPORT,
        S_NEXT,
        S_FINISH
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);
    localparam logic [TAP_W-1:0] LP_TAP_ONE = TAP_W'(1);
    localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] LP_SET_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [TAP_W-1:0] r_cur;
    logic [TAP_W-1:0] r_step;
    logic [TAP_W-1:0] r_last;
    logic [TAP_W-1:0] r_rb;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_ones;
    logic             r_terr;
    logic             r_sync1;
    logic             r_sync2;

    logic [TAP_W:0] w_nxt;
    logic           w_stop;
    logic           w_to;
    logic           w_settle_end;
    logic           w_sample_end;

    // Next tap is computed one bit wider so a wrap past the top tap ends the scan
    assign w_nxt        = {1'b0, r_cur} + {1'b0, r_step};
    assign w_stop       = w_nxt[TAP_W] || (w_nxt[TAP_W-1:0] > r_last);
    assign w_to         = (r_cnt == LP_TO_LAST);
    assign w_settle_end = (r_cnt == LP_SET_LAST);
    assign w_sample_end = (r_cnt == (r_len - LP_CNT_ONE));

    assign timeout_err  = r_terr;
    assign dly_value    = r_cur;
    assign res_tap      = r_cur;
    assign res_readback = r_rb;
    assign res_ones     = r_ones;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        scan_done   = 1'b0;
        dly_change  = 1'b0;
        res_valid   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                busy        = 1'b1;
                dly_change  = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (dly_done) w_state_nxt = S_SETTLE;
                else if (w_to) w_state_nxt = S_FINISH;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (w_settle_end) w_state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                busy = 1'b1;
                if (w_sample_end) w_state_nxt = S_REPORT;
            end
            S_REPORT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                busy        = 1'b1;
                w_state_nxt = w_stop ? S_FINISH : S_REQ;
            end
            S_FINISH: begin
                scan_done   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= data_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur  <= '0;
            r_step <= '0;
            r_last <= '0;
            r_rb   <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_ones <= '0;
            r_terr <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cur  <= tap_first;
                        r_step <= (tap_step == '0) ? LP_TAP_ONE : tap_step;
                        r_last <= tap_last;
                        r_len  <= (sample_len == '0) ? LP_CNT_ONE : sample_len;
                        r_terr <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                S_REQ: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    if (dly_done) begin
                        r_rb  <= dly_readback;
                        r_cnt <= '0;
                    end else if (w_to) begin
                        r_terr <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + LP_CNT_ONE;
                    end
                end
                S_SETTLE: begin
                    if (w_settle_end) begin
                        r_cnt  <= '0;
                        r_ones <= '0;
                    end else begin
                        r_cnt <= r_cnt + LP_CNT_ONE;
                    end
                end
                S_SAMPLE: begin
                    r_cnt <= r_cnt + LP_CNT_ONE;
                    if (r_sync2 && (r_ones != '1)) begin
                        r_ones <= r_ones + LP_CNT_ONE;
                    end
                end
                S_NEXT: begin
                    if (!w_stop) r_cur <= w_nxt[TAP_W-1:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_scan_ctrl.sv
// Bench for delay_scan_ctrl: delay-block model plus scoreboard of
// expected per-tap results, one task per scenario.
module tb_delay_scan_ctrl;

    localparam int SETTLE = 8;
    localparam int TO     = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  tap_first = '0;
    logic [8:0]  tap_last = '0;
    logic [8:0]  tap_step = '0;
    logic [15:0] sample_len = '0;
    logic        busy;
    logic        scan_done;
    logic        timeout_err;
    logic        dly_change;
    logic [8:0]  dly_value;
    logic        dly_done = 1'b0;
    logic [8:0]  dly_readback = '0;
    logic        data_in = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [8:0]  res_tap;
    logic [8:0]  res_readback;
    logic [15:0] res_ones;

    delay_scan_ctrl #(
        .TAP_W(9), .CNT_W(16), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .tap_first(tap_first), .tap_last(tap_last),
        .tap_step(tap_step), .sample_len(sample_len),
        .busy(busy), .scan_done(scan_done),
        .timeout_err(timeout_err), .dly_change(dly_change),
        .dly_value(dly_value), .dly_done(dly_done),
        .dly_readback(dly_readback), .data_in(data_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_tap(res_tap), .res_readback(res_readback),
        .res_ones(res_ones)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tap;
        int rb;
        int ones;
    } exp_t;

    exp_t q[$];
    exp_t m_e;

    int n_vec = 0;
    int n_bad = 0;

    bit   model_en = 1'b1;
    int   model_lat = 20;
    int   rb_ofs = 0;
    int   m_cnt = 0;
    logic [8:0] m_val = '0;

    int   cyc = 0;
    int   n_chg = 0;
    int   n_done = 0;
    int   n_valid = 0;
    int   n_dd = 0;
    int   chg_cyc = 0;
    int   sd_cyc = 0;
    int   dd_cyc = 0;
    int   cur_len = 1;
    logic prev_valid = 1'b0;

    // Delay-block model: pulses done model_lat cycles after a change
    always begin
        @(posedge clk);
        #2;
        dly_done = 1'b0;
        if (!rst_n) begin
            m_cnt = 0;
        end else begin
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    dly_done     = 1'b1;
                    dly_readback = m_val;
                end
            end
            if (dly_change && model_en) begin
                m_cnt = model_lat;
                m_val = dly_value + 9'(rb_ofs);
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (dly_change) begin
            n_chg++;
            chg_cyc = cyc;
        end
        if (dly_done) begin
            n_dd++;
            dd_cyc = cyc;
        end
        if (scan_done) begin
            n_done++;
            sd_cyc = cyc;
        end
        if (res_valid && !prev_valid) begin
            n_valid++;
            n_vec++;
            if (cyc - dd_cyc != SETTLE + cur_len + 1) begin
                n_bad++;
                $display("FAIL res_latency: got %0d cycles, want %0d",
                         cyc - dd_cyc, SETTLE + cur_len + 1);
            end
        end
        if (res_valid && res_ready) begin
            n_vec++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL res_extra: got tap=%0d, want no result",
                         res_tap);
            end else begin
                m_e = q.pop_front();
                if (res_tap !== 9'(m_e.tap) ||
                    res_readback !== 9'(m_e.rb) ||
                    res_ones !== 16'(m_e.ones)) begin
                    n_bad++;
                    $display("FAIL res_fields: got tap=%0d rb=%0d ones=%0d, want tap=%0d rb=%0d ones=%0d",
                             res_tap, res_readback, res_ones,
                             m_e.tap, m_e.rb, m_e.ones);
                end
            end
        end
        prev_valid = res_valid;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: got no finish, want finish before 95000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic clr_counts();
        n_chg   = 0;
        n_done  = 0;
        n_valid = 0;
        n_dd    = 0;
    endtask

    task automatic launch(input int first, input int last,
                          input int step, input int len,
                          input logic din);
        int se;
        int le;
        int t;
        exp_t e;
        se = (step == 0) ? 1 : step;
        le = (len == 0) ? 1 : len;
        cur_len = le;
        t = first;
        do begin
            e.tap  = t;
            e.rb   = (t + rb_ofs) % 512;
            e.ones = din ? le : 0;
            q.push_back(e);
            t += se;
        end while (t <= last && t < 512);
        @(posedge clk);
        #1;
        tap_first  = 9'(first);
        tap_last   = 9'(last);
        tap_step   = 9'(step);
        sample_len = 16'(len);
        data_in    = din;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_scan(input int budget, input string nm);
        int k;
        k = 0;
        while (n_done == 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        n_vec++;
        if (n_done == 0) begin
            n_bad++;
            $display("FAIL %s_done: got no scan_done, want one within %0d cycles",
                     nm, budget);
        end
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if ({busy, scan_done, timeout_err, dly_change, res_valid} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b, want 00000",
                     {busy, scan_done, timeout_err, dly_change, res_valid});
        end
        n_vec++;
        if ({dly_value, res_tap, res_readback, res_ones} !== 43'b0) begin
            n_bad++;
            $display("FAIL reset_data: got %h, want 0",
                     {dly_value, res_tap, res_readback, res_ones});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || scan_done !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0",
                     busy, scan_done);
        end
    endtask

    task automatic test_basic();
        clr_counts();
        model_en = 1'b1;
        model_lat = 20;
        rb_ofs = 0;
        launch(0, 20, 10, 4, 1'b1);
        n_vec++;
        if (busy !== 1'b1 || dly_change !== 1'b1) begin
            n_bad++;
            $display("FAIL start_latency: got busy=%b chg=%b, want 1 1",
                     busy, dly_change);
        end
        wait_scan(500, "basic");
        n_vec++;
        if (n_chg != 3 || n_done != 1 || timeout_err !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_counts: got chg=%0d done=%0d terr=%b, want 3 1 0",
                     n_chg, n_done, timeout_err);
        end
        n_vec++;
        if (q.size() != 0 || busy !== 1'b0 || n_valid != 3) begin
            n_bad++;
            $display("FAIL basic_drain: got left=%0d busy=%b res=%0d, want 0 0 3",
                     q.size(), busy, n_valid);
        end
    endtask

    task automatic test_step_len_zero();
        clr_counts();
        model_lat = 5;
        rb_ofs = 3;
        launch(5, 7, 0, 0, 1'b0);
        wait_scan(300, "zero");
        n_vec++;
        if (n_chg != 3 || q.size() != 0 || n_valid != 3) begin
            n_bad++;
            $display("FAIL zero_counts: got chg=%0d left=%0d res=%0d, want 3 0 3",
                     n_chg, q.size(), n_valid);
        end
    endtask

    task automatic test_overflow();
        clr_counts();
        model_lat = 3;
        rb_ofs = 7;
        launch(500, 511, 8, 2, 1'b1);
        wait_scan(300, "ovf");
        n_vec++;
        if (n_chg != 2 || q.size() != 0 || n_valid != 2) begin
            n_bad++;
            $display("FAIL ovf_counts: got chg=%0d left=%0d res=%0d, want 2 0 2",
                     n_chg, q.size(), n_valid);
        end
        clr_counts();
        launch(9, 3, 1, 3, 1'b1);
        wait_scan(300, "inv");
        n_vec++;
        if (n_chg != 1 || q.size() != 0 || n_valid != 1) begin
            n_bad++;
            $display("FAIL inv_counts: got chg=%0d left=%0d res=%0d, want 1 0 1",
                     n_chg, q.size(), n_valid);
        end
    endtask

    task automatic test_timeout();
        clr_counts();
        model_en = 1'b0;
        launch(2, 100, 1, 1, 1'b1);
        q.delete();
        wait_scan(300, "timeout");
        n_vec++;
        if (sd_cyc - chg_cyc != TO + 1) begin
            n_bad++;
            $display("FAIL timeout_latency: got %0d, want %0d",
                     sd_cyc - chg_cyc, TO + 1);
        end
        n_vec++;
        if (timeout_err !== 1'b1 || n_chg != 1 || n_valid != 0) begin
            n_bad++;
            $display("FAIL timeout_state: got terr=%b chg=%0d res=%0d, want 1 1 0",
                     timeout_err, n_chg, n_valid);
        end
        clr_counts();
        model_en = 1'b1;
        model_lat = 6;
        launch(30, 30, 1, 2, 1'b0);
        n_vec++;
        if (timeout_err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_clear: got %b, want 0", timeout_err);
        end
        wait_scan(300, "after_to");
        n_vec++;
        if (q.size() != 0 || timeout_err !== 1'b0 || n_valid != 1) begin
            n_bad++;
            $display("FAIL after_to: got left=%0d terr=%b res=%0d, want 0 0 1",
                     q.size(), timeout_err, n_valid);
        end
    endtask

    task automatic test_backpressure();
        int k;
        int bad;
        clr_counts();
        model_lat = 4;
        rb_ofs = 3;
        res_ready = 1'b0;
        launch(0, 4, 4, 3, 1'b1);
        k = 0;
        while (res_valid !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (res_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_valid: got %b, want 1", res_valid);
        end
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_tap !== 9'd0 ||
                res_readback !== 9'd3 || res_ones !== 16'd3 || n_chg != 1)
                bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL bp_hold: got %0d unstable cycles, want 0", bad);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_scan(300, "bp");
        n_vec++;
        if (n_chg != 2 || q.size() != 0 || n_valid != 2) begin
            n_bad++;
            $display("FAIL bp_counts: got chg=%0d left=%0d res=%0d, want 2 0 2",
                     n_chg, q.size(), n_valid);
        end
    endtask

    task automatic test_saturation();
        clr_counts();
        model_lat = 4;
        rb_ofs = 0;
        launch(0, 0, 1, 65535, 1'b1);
        wait_scan(70000, "sat");
        n_vec++;
        if (q.size() != 0 || n_valid != 1) begin
            n_bad++;
            $display("FAIL sat_counts: got left=%0d res=%0d, want 0 1",
                     q.size(), n_valid);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        clr_counts();
        model_lat = 4;
        rb_ofs = 5;
        launch(0, 10, 5, 200, 1'b1);
        k = 0;
        while (n_dd == 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        repeat (SETTLE + 20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, scan_done, timeout_err, dly_change, res_valid,
             dly_value, res_tap, res_readback, res_ones} !== 48'b0) begin
            n_bad++;
            $display("FAIL mid_reset_outs: got busy=%b ones=%0d tap=%0d, want all 0",
                     busy, res_ones, res_tap);
        end
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        n_vec++;
        if (n_done != 0 || busy !== 1'b0 || n_valid != 0) begin
            n_bad++;
            $display("FAIL mid_reset_quiet: got done=%0d busy=%b res=%0d, want 0 0 0",
                     n_done, busy, n_valid);
        end
        clr_counts();
        launch(0, 10, 5, 2, 1'b1);
        wait_scan(400, "post_rst");
        n_vec++;
        if (n_chg != 3 || q.size() != 0 || n_done != 1 || n_valid != 3) begin
            n_bad++;
            $display("FAIL post_rst_counts: got chg=%0d left=%0d done=%0d res=%0d, want 3 0 1 3",
                     n_chg, q.size(), n_done, n_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_step_len_zero();
        test_overflow();
        test_timeout();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
